// File: rtl/c_element_sync.sv
// c_element_sync: clocked Muller C-element bank with registered per-lane rise/fall pulses.
// Optional per-lane disagreement watchdog, built only when C_ELEMENT_WATCHDOG_EN is defined.
module c_element_sync #(
  parameter int unsigned WIDTH     = 1,
  parameter logic        RESET_VAL = 1'b0,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] stall
);

  if (WIDTH < 1 || WIDTH > 64 || TIMEOUT < 2 || TIMEOUT > 65535) begin : g_param_check
    $error("c_element_sync: WIDTH must be 1..64 and TIMEOUT 2..65535");
  end

  logic [WIDTH-1:0] agree;
  logic [WIDTH-1:0] c_d;
  logic [WIDTH-1:0] c_q;
  logic [WIDTH-1:0] rise_d;
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] fall_d;
  logic [WIDTH-1:0] fall_q;

  // Pulses are computed from the pre-edge state so they land together with the c change.
  always_comb begin
    agree  = ~(a ^ b);
    c_d    = (agree & a) | (~agree & c_q);
    rise_d = a & b & ~c_q;
    fall_d = ~(a | b) & c_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      c_q    <= {WIDTH{RESET_VAL}};
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      c_q    <= c_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign c    = c_q;
  assign rise = rise_q;
  assign fall = fall_q;

`ifdef C_ELEMENT_WATCHDOG_EN
  localparam int unsigned       CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [WIDTH-1:0] stall_d;
  logic [WIDTH-1:0] stall_q;

  // Counter saturates at TIMEOUT; stall reflects the post-edge count.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      if (agree[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        cnt_d[i] = cnt_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
      stall_d[i] = (cnt_d[i] >= CNT_MAX);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
      stall_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
    end
  end

  assign stall = stall_q;
`else
  assign stall = '0;
`endif

endmodule

// File: tb/tb_c_element_sync.sv
// Bench for c_element_sync: directed scenarios on a 1-lane and a 4-lane instance,
// then randomized traffic checked against a per-lane behavioural model.
module tb_c_element_sync;

  localparam int TMO = 4;
`ifdef C_ELEMENT_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst1, a1, b1, c1, rise1, fall1, stall1;
  logic       rst4;
  logic [3:0] a4, b4, c4, rise4, fall4, stall4;

  c_element_sync #(.WIDTH(1), .RESET_VAL(1'b0), .TIMEOUT(TMO)) dut1 (
    .clk(clk), .rst(rst1), .a(a1), .b(b1),
    .c(c1), .rise(rise1), .fall(fall1), .stall(stall1)
  );

  c_element_sync #(.WIDTH(4), .RESET_VAL(1'b0), .TIMEOUT(TMO)) dut4 (
    .clk(clk), .rst(rst4), .a(a4), .b(b4),
    .c(c4), .rise(rise4), .fall(fall4), .stall(stall4)
  );

  int checks = 0;
  int passed = 0;

  // model state
  logic       m1_c = 1'b0, m1_rise = 1'b0, m1_fall = 1'b0, m1_stall = 1'b0;
  int         m1_cnt = 0;
  logic [3:0] m4_c = '0, m4_rise = '0, m4_fall = '0, m4_stall = '0;
  int         m4_cnt [4] = '{0, 0, 0, 0};

  task automatic lane_step(input logic ai, input logic bi, input logic r,
                           inout logic c, inout int cnt,
                           output logic rs, output logic fl, output logic st);
    logic nc;
    if (r) begin
      c = 1'b0; cnt = 0; rs = 1'b0; fl = 1'b0; st = 1'b0;
    end else begin
      nc  = (ai == bi) ? ai : c;
      rs  = (c == 1'b0) && (nc == 1'b1);
      fl  = (c == 1'b1) && (nc == 1'b0);
      cnt = (ai == bi) ? 0 : ((cnt + 1 > TMO) ? TMO : cnt + 1);
      st  = WD && (cnt >= TMO);
      c   = nc;
    end
  endtask

  task automatic tick();
    logic cc, rr, ff, ss;
    int n;
    cc = m1_c; n = m1_cnt;
    lane_step(a1, b1, rst1, cc, n, rr, ff, ss);
    m1_c = cc; m1_cnt = n; m1_rise = rr; m1_fall = ff; m1_stall = ss;
    for (int i = 0; i < 4; i++) begin
      cc = m4_c[i]; n = m4_cnt[i];
      lane_step(a4[i], b4[i], rst4, cc, n, rr, ff, ss);
      m4_c[i] = cc; m4_cnt[i] = n; m4_rise[i] = rr; m4_fall[i] = ff; m4_stall[i] = ss;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst1 = 1'b1; a1 = 1'b1; b1 = 1'b1;
    rst4 = 1'b1; a4 = 4'b1111; b4 = 4'b1111;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if ({c1, rise1, fall1, stall1} !== 4'b0000)
        $display("FAIL reset1 cyc%0d c/rise/fall/stall got %b want 0000", k, {c1, rise1, fall1, stall1});
      else passed++;
      checks++;
      if ({c4, rise4, fall4, stall4} !== 16'h0000)
        $display("FAIL reset4 cyc%0d got %h want 0000", k, {c4, rise4, fall4, stall4});
      else passed++;
    end
    rst1 = 1'b0;
    rst4 = 1'b0; a4 = 4'b0000; b4 = 4'b0000;
    tick();
    checks++;
    if ({c1, rise1, fall1, stall1} !== 4'b1100)
      $display("FAIL release_rise got %b want 1100", {c1, rise1, fall1, stall1});
    else passed++;
    tick();
    checks++;
    if ({c1, rise1, fall1, stall1} !== 4'b1000)
      $display("FAIL release_hold got %b want 1000", {c1, rise1, fall1, stall1});
    else passed++;
  endtask

  task automatic test_hysteresis();
    a1 = 1'b0; b1 = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      checks++;
      if ({c1, rise1, fall1, stall1} !== {3'b100, WD && (k >= TMO)})
        $display("FAIL hyst_hold k%0d got %b want %b", k, {c1, rise1, fall1, stall1},
                 {3'b100, WD && (k >= TMO)});
      else passed++;
    end
    a1 = 1'b0; b1 = 1'b0;
    tick();
    checks++;
    if ({c1, rise1, fall1, stall1} !== 4'b0010)
      $display("FAIL hyst_fall got %b want 0010", {c1, rise1, fall1, stall1});
    else passed++;
    tick();
    checks++;
    if ({c1, rise1, fall1, stall1} !== 4'b0000)
      $display("FAIL hyst_fall_once got %b want 0000", {c1, rise1, fall1, stall1});
    else passed++;
  endtask

  task automatic test_lanes();
    a4 = 4'b1010; b4 = 4'b1100;
    tick();
    checks++;
    if ({c4, rise4, fall4, stall4} !== 16'b1000_1000_0000_0000)
      $display("FAIL lanes_rise got %b want 1000100000000000", {c4, rise4, fall4, stall4});
    else passed++;
    a4 = 4'b0000; b4 = 4'b0000;
    tick();
    checks++;
    if ({c4, rise4, fall4, stall4} !== 16'b0000_0000_1000_0000)
      $display("FAIL lanes_fall got %b want 0000000010000000", {c4, rise4, fall4, stall4});
    else passed++;
  endtask

  task automatic test_mid_reset();
    a1 = 1'b1; b1 = 1'b1;
    tick();
    checks++;
    if ({c1, rise1, fall1, stall1} !== 4'b1100)
      $display("FAIL midrst_set got %b want 1100", {c1, rise1, fall1, stall1});
    else passed++;
    rst1 = 1'b1;
    tick();
    checks++;
    if ({c1, rise1, fall1, stall1} !== 4'b0000)
      $display("FAIL midrst_clear got %b want 0000", {c1, rise1, fall1, stall1});
    else passed++;
    rst1 = 1'b0;
    tick();
    checks++;
    if ({c1, rise1, fall1, stall1} !== 4'b1100)
      $display("FAIL midrst_follow got %b want 1100", {c1, rise1, fall1, stall1});
    else passed++;
  endtask

  task automatic test_watchdog();
    a1 = 1'b0; b1 = 1'b0;
    tick();
    checks++;
    if ({c1, rise1, fall1, stall1} !== 4'b0010)
      $display("FAIL wd_prep got %b want 0010", {c1, rise1, fall1, stall1});
    else passed++;
    a1 = 1'b1; b1 = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      tick();
      checks++;
      if ({c1, rise1, fall1, stall1} !== {3'b000, WD && (k >= TMO)})
        $display("FAIL wd_stall k%0d got %b want %b", k, {c1, rise1, fall1, stall1},
                 {3'b000, WD && (k >= TMO)});
      else passed++;
    end
    b1 = 1'b1;
    tick();
    checks++;
    if ({c1, rise1, fall1, stall1} !== 4'b1100)
      $display("FAIL wd_release got %b want 1100", {c1, rise1, fall1, stall1});
    else passed++;
  endtask

  task automatic test_random();
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 2) == 0) a1 = 1'($urandom);
      if ($urandom_range(0, 2) == 0) b1 = 1'($urandom);
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 2) == 0) a4[i] = 1'($urandom);
        if ($urandom_range(0, 2) == 0) b4[i] = 1'($urandom);
      end
      rst1 = ($urandom_range(0, 49) == 0);
      rst4 = ($urandom_range(0, 49) == 0);
      tick();
      checks++;
      if ({c1, rise1, fall1, stall1} !== {m1_c, m1_rise, m1_fall, m1_stall})
        $display("FAIL rand1 n%0d got %b want %b", n, {c1, rise1, fall1, stall1},
                 {m1_c, m1_rise, m1_fall, m1_stall});
      else passed++;
      checks++;
      if ({c4, rise4, fall4, stall4} !== {m4_c, m4_rise, m4_fall, m4_stall})
        $display("FAIL rand4 n%0d got %b want %b", n, {c4, rise4, fall4, stall4},
                 {m4_c, m4_rise, m4_fall, m4_stall});
      else passed++;
    end
  endtask

  initial begin
    rst1 = 1'b1; a1 = 1'b0; b1 = 1'b0;
    rst4 = 1'b1; a4 = '0;   b4 = '0;
    #2;
    test_reset();
    test_hysteresis();
    test_lanes();
    test_mid_reset();
    test_watchdog();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
